gtxe2_oob_ctrl: RTL
===================

Name: gtxe2_oob_ctrl

Overview:
- Host-side SATA out-of-band (OOB) and link-bring-up sequencer. Sits directly upstream of the gtxe2_chnl transceiver model.
- Drives TXCOMINIT/TXCOMWAKE/TXELECIDLE/TXDATA/TXCHARISK and consumes RXCOMINITDET/RXCOMWAKEDET/RXELECIDLE/RXBYTEISALIGNED/RXDATA/RXCHARISK.
- Runs COMINIT → COMWAKE → D10.2 → ALIGN handshake, then passes user dwords through as 16-bit words (TX_DATA_WIDTH=20 with 8b10b).

Parameters:
- COMINIT_TIMEOUT, 1500000: clk cycles to wait for RXCOMINITDET or RXCOMWAKEDET (10 ms @150 MHz).
- ALIGN_TIMEOUT, 132000: clk cycles allowed for the RX-idle-exit, D10.2 and ALIGN phases (880 us).
- IDLE_LOSS, 16: consecutive cycles of rxelecidle in READY that count as link loss.
- NONALIGN_CNT, 3: consecutive non-ALIGN primitives required to declare link up.

Ports:
- clk  in  1  TXUSRCLK2; RX user clock is the same domain.
- reset_n  in  1  reset.
- link_reset_req  in  1  level; forces IDLE while high.
- link_up  out  1  high in READY.
- oob_state  out  4  current state encoding.
- oob_error  out  1  one-cycle pulse on any timeout.
- retry_cnt  out  8  timeout count, saturating.
- txcominit  out  1  → TXCOMINIT.
- txcomwake  out  1  → TXCOMWAKE.
- txcomfinish  in  1  ← TXCOMFINISH.
- txelecidle  out  1  → TXELECIDLE.
- txdata  out  16  → TXDATA[15:0].
- txcharisk  out  2  → TXCHARISK[1:0].
- rxcominitdet  in  1.
- rxcomwakedet  in  1.
- rxelecidle  in  1.
- rxbyteisaligned  in  1.
- rxdata  in  16.
- rxcharisk  in  2.
- user_txdata  in  16.
- user_txcharisk  in  2.
- user_rxdata  out  16.
- user_rxcharisk  out  2.
- user_rxvalid  out  1.

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous, active-low.
- Reset values:
  - state IDLE, txelecidle=1.
  - txcominit, txcomwake, txdata, txcharisk, link_up, oob_error, retry_cnt, user_rx* all 0.
- All outputs are registered. User TX and user RX paths each have 1-cycle latency.
- States (oob_state):
  - IDLE=0: next cycle → COMINIT, unless link_reset_req=1.
  - COMINIT=1: txcominit=1 for the first cycle only. Wait txcomfinish → WAIT_COMINIT.
  - WAIT_COMINIT=2: rxcominitdet → COMWAKE. COMINIT_TIMEOUT → COMINIT.
  - COMWAKE=3: txcomwake=1 for the first cycle only. Wait txcomfinish → WAIT_COMWAKE.
  - WAIT_COMWAKE=4: rxcomwakedet → WAIT_RXACT. COMINIT_TIMEOUT → COMINIT.
  - WAIT_RXACT=5: rxelecidle=0 → SEND_D10. ALIGN_TIMEOUT → COMINIT.
  - SEND_D10=6: txdata=16'h4A4A, txcharisk=00. (align_det && rxbyteisaligned) → SEND_ALIGN. ALIGN_TIMEOUT → COMINIT.
  - SEND_ALIGN=7: transmit ALIGN as alternating words W0=16'h4ABC/k=01 and W1=16'h7B4A/k=00, tracked by tx_phase.
    - Once NONALIGN_CNT consecutive non-ALIGN primitives are received, move to READY only on a cycle where the next word would be W0 (dword boundary).
    - ALIGN_TIMEOUT → COMINIT.
  - READY=8: link_up=1; txdata/txcharisk = registered user_tx*.
    - Leave to COMINIT on rxcominitdet, or on rxelecidle high for IDLE_LOSS consecutive cycles.
- txelecidle=1 in states 0–5, 0 in states 6–8.
- RX primitive detect:
  - align_det: word {4ABC,k=01} followed next cycle by {7B4A,k=00}.
  - nonalign prim: word with rxcharisk[0]=1 and rxdata[7:0]=8'h7C (K28.3).
  - Each ALIGN clears the non-ALIGN counter. Other words leave it unchanged.
- Timeout counter (21 bits): clears on every state change; counts in states 2, 4, 5, 6, 7.
- On timeout:
  - oob_error pulses one cycle.
  - retry_cnt increments, saturating at 255.
  - retry_cnt clears on entry to READY.
- user_rxvalid = link_up delayed 1 cycle. user_rxdata/charisk = rxdata/charisk delayed 1 cycle, and forced to 0 when not link_up.
- Priority: link_reset_req > timeout > normal transition.
  - link_reset_req from any state → IDLE next cycle; txelecidle=1, link_up=0.
  - In WAIT_COMINIT, simultaneous rxcominitdet and timeout: detect wins.
- txcomfinish arriving in any state other than 1/3: ignored.
- reset_n asserted mid-sequence: all outputs return to reset values asynchronously.

Decomposition:
- Package gtxe2_oob_pkg holds:
  - the state enum;
  - constants ALIGN_W0=16'h4ABC, ALIGN_W1=16'h7B4A, D10_2_W=16'h4A4A, K28_3=8'h7C, K28_5=8'hBC.
- Sub-module gtxe2_oob_prim_det: registered rxdata/rxcharisk → align_det and nonalign_det pulses.

Test Plan:
- Device answers COMINIT after 100 cycles and COMWAKE after 100; rxelecidle drops; RX sends 2 ALIGNs then 3 K28.3 primitives. Required:
  - oob_state goes 1,2,3,4,5,6,7,8;
  - txcominit and txcomwake are single-cycle pulses;
  - link_up=1;
  - the first user word appears on txdata exactly 1 cycle after READY, landing on W0 phase.
- No rxcominitdet with COMINIT_TIMEOUT=50. Required: oob_error pulses every 50 cycles in state 2; retry_cnt counts 1,2,3 with a re-pulse of txcominit each time; retry_cnt saturates at 255.
- In SEND_ALIGN, RX sends K28.3, K28.3, ALIGN, K28.3×3. Required: READY is reached only after the final 3-run, not after 2.
- In READY, rxelecidle high for 15 cycles then low. Required: stays READY. Holding it for 16 cycles → state COMINIT and link_up=0.
- link_reset_req pulsed in SEND_D10 together with a timeout. Required: IDLE next cycle, oob_error=0, txelecidle=1.
- Assert reset_n=0 asynchronously mid-COMWAKE. Required: all outputs go to reset values with no clock edge; after release the sequence restarts from IDLE→COMINIT.

Source files
------------

// File: rtl/gtxe2_oob_pkg.sv
// Shared state encoding and SATA primitive constants for the host-side OOB sequencer.
package gtxe2_oob_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_COMINIT      = 4'd1,
    ST_WAIT_COMINIT = 4'd2,
    ST_COMWAKE      = 4'd3,
    ST_WAIT_COMWAKE = 4'd4,
    ST_WAIT_RXACT   = 4'd5,
    ST_SEND_D10     = 4'd6,
    ST_SEND_ALIGN   = 4'd7,
    ST_READY        = 4'd8
  } oob_state_e;

  localparam logic [15:0] ALIGN_W0 = 16'h4ABC;
  localparam logic [15:0] ALIGN_W1 = 16'h7B4A;
  localparam logic [1:0]  ALIGN_K0 = 2'b01;
  localparam logic [1:0]  ALIGN_K1 = 2'b00;
  localparam logic [15:0] D10_2_W  = 16'h4A4A;
  localparam logic [7:0]  K28_3    = 8'h7C;
  localparam logic [7:0]  K28_5    = 8'hBC;

  // States in which the shared timeout counter runs.
  function automatic logic is_tmo_state(input oob_state_e s);
    return (s == ST_WAIT_COMINIT) || (s == ST_WAIT_COMWAKE) || (s == ST_WAIT_RXACT) ||
           (s == ST_SEND_D10) || (s == ST_SEND_ALIGN);
  endfunction

endpackage

// File: rtl/gtxe2_oob_prim_det.sv
// Registers the RX word stream and flags the ALIGN dword and K28.3-led (non-ALIGN) primitives.
module gtxe2_oob_prim_det
  import gtxe2_oob_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] rxdata_i,
  input  logic [1:0]  rxcharisk_i,
  output logic        align_det_o,
  output logic        nonalign_det_o
);

  logic [15:0] rxd_q;
  logic [1:0]  rxk_q;
  logic        w0_seen_q;
  logic        is_w0;

  assign is_w0 = (rxk_q == ALIGN_K0) && (rxd_q[7:0] == K28_5) && (rxd_q[15:8] == ALIGN_W0[15:8]);

  // RX word pipeline plus "previous word was ALIGN W0" flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_q     <= 16'h0000;
      rxk_q     <= 2'b00;
      w0_seen_q <= 1'b0;
    end else begin
      rxd_q     <= rxdata_i;
      rxk_q     <= rxcharisk_i;
      w0_seen_q <= is_w0;
    end
  end

  assign align_det_o    = w0_seen_q && (rxd_q == ALIGN_W1) && (rxk_q == ALIGN_K1);
  assign nonalign_det_o = rxk_q[0] && (rxd_q[7:0] == K28_3);

endmodule

// File: rtl/gtxe2_oob_ctrl.sv
// Host-side SATA OOB / link bring-up sequencer: COMINIT, COMWAKE, D10.2, ALIGN, then user pass-through.
module gtxe2_oob_ctrl
  import gtxe2_oob_pkg::*;
#(
  parameter int COMINIT_TIMEOUT = 1500000,
  parameter int ALIGN_TIMEOUT   = 132000,
  parameter int IDLE_LOSS       = 16,
  parameter int NONALIGN_CNT    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        link_reset_req,
  output logic        link_up,
  output logic [3:0]  oob_state,
  output logic        oob_error,
  output logic [7:0]  retry_cnt,
  output logic        txcominit,
  output logic        txcomwake,
  input  logic        txcomfinish,
  output logic        txelecidle,
  output logic [15:0] txdata,
  output logic [1:0]  txcharisk,
  input  logic        rxcominitdet,
  input  logic        rxcomwakedet,
  input  logic        rxelecidle,
  input  logic        rxbyteisaligned,
  input  logic [15:0] rxdata,
  input  logic [1:0]  rxcharisk,
  input  logic [15:0] user_txdata,
  input  logic [1:0]  user_txcharisk,
  output logic [15:0] user_rxdata,
  output logic [1:0]  user_rxcharisk,
  output logic        user_rxvalid
);

  localparam logic [20:0] CI_LIM   = 21'(COMINIT_TIMEOUT - 1);
  localparam logic [20:0] AL_LIM   = 21'(ALIGN_TIMEOUT - 1);
  localparam logic [7:0]  IDLE_LIM = 8'(IDLE_LOSS - 1);
  localparam logic [3:0]  NA_LIM   = 4'(NONALIGN_CNT);

  oob_state_e  state_q, state_d;
  logic [20:0] tmo_q, tmo_d;
  logic [7:0]  idle_q, idle_d;
  logic [3:0]  na_q, na_d;
  logic        tx_phase_q, tx_phase_d;
  logic [7:0]  retry_q, retry_d;

  logic        txcominit_q, txcomwake_q, txelecidle_q, link_up_q, oob_error_q;
  logic [15:0] txdata_q, user_rxdata_q;
  logic [1:0]  txcharisk_q, user_rxcharisk_q;
  logic        user_rxvalid_q;

  logic        align_det, nonalign_det;
  logic        tmo_hit, timeout, idle_loss, na_done;
  logic [15:0] tx_word;
  logic [1:0]  tx_k;

  gtxe2_oob_prim_det u_prim_det (
    .clk            (clk),
    .reset_n        (reset_n),
    .rxdata_i       (rxdata),
    .rxcharisk_i    (rxcharisk),
    .align_det_o    (align_det),
    .nonalign_det_o (nonalign_det)
  );

  // Timeout qualification; a COMINIT answer arriving on the last wait cycle beats the timeout.
  always_comb begin
    case (state_q)
      ST_WAIT_COMINIT, ST_WAIT_COMWAKE:           tmo_hit = (tmo_q == CI_LIM);
      ST_WAIT_RXACT, ST_SEND_D10, ST_SEND_ALIGN:  tmo_hit = (tmo_q == AL_LIM);
      default:                                    tmo_hit = 1'b0;
    endcase
    timeout   = tmo_hit && !link_reset_req && !((state_q == ST_WAIT_COMINIT) && rxcominitdet);
    idle_loss = rxelecidle && (idle_q == IDLE_LIM);
    na_done   = (na_q >= NA_LIM);
  end

  // Next-state logic: link_reset_req, then timeout, then the normal handshake step.
  always_comb begin
    state_d = state_q;
    if (link_reset_req) begin
      state_d = ST_IDLE;
    end else if (timeout) begin
      state_d = ST_COMINIT;
    end else begin
      case (state_q)
        ST_IDLE:         state_d = ST_COMINIT;
        ST_COMINIT:      state_d = txcomfinish ? ST_WAIT_COMINIT : ST_COMINIT;
        ST_WAIT_COMINIT: state_d = rxcominitdet ? ST_COMWAKE : ST_WAIT_COMINIT;
        ST_COMWAKE:      state_d = txcomfinish ? ST_WAIT_COMWAKE : ST_COMWAKE;
        ST_WAIT_COMWAKE: state_d = rxcomwakedet ? ST_WAIT_RXACT : ST_WAIT_COMWAKE;
        ST_WAIT_RXACT:   state_d = rxelecidle ? ST_WAIT_RXACT : ST_SEND_D10;
        ST_SEND_D10:     state_d = (align_det && rxbyteisaligned) ? ST_SEND_ALIGN : ST_SEND_D10;
        // Leave only after W1 has been loaded so the first user word lands on a dword boundary.
        ST_SEND_ALIGN:   state_d = (na_done && tx_phase_q) ? ST_READY : ST_SEND_ALIGN;
        ST_READY:        state_d = (rxcominitdet || idle_loss) ? ST_COMINIT : ST_READY;
        default:         state_d = ST_IDLE;
      endcase
    end
  end

  // Counters and TX phase next values.
  always_comb begin
    tmo_d      = ((state_d != state_q) || !is_tmo_state(state_q)) ? 21'd0 : tmo_q + 21'd1;
    idle_d     = ((state_q == ST_READY) && rxelecidle) ? idle_q + 8'd1 : 8'd0;
    tx_phase_d = (state_q == ST_SEND_ALIGN) ? ~tx_phase_q : 1'b0;
    if (state_q != ST_SEND_ALIGN) begin
      na_d = 4'd0;
    end else if (align_det) begin
      na_d = 4'd0;
    end else if (nonalign_det && !na_done) begin
      na_d = na_q + 4'd1;
    end else begin
      na_d = na_q;
    end
    if ((state_d == ST_READY) && (state_q != ST_READY)) begin
      retry_d = 8'd0;
    end else if (timeout && (retry_q != 8'hFF)) begin
      retry_d = retry_q + 8'd1;
    end else begin
      retry_d = retry_q;
    end
  end

  // TX word selection; zeroed whenever the link is heading back into electrical idle.
  always_comb begin
    tx_word = 16'h0000;
    tx_k    = 2'b00;
    if ((state_d == ST_SEND_D10) || (state_d == ST_SEND_ALIGN) || (state_d == ST_READY)) begin
      case (state_q)
        ST_SEND_D10: begin
          tx_word = D10_2_W;
          tx_k    = 2'b00;
        end
        ST_SEND_ALIGN: begin
          tx_word = tx_phase_q ? ALIGN_W1 : ALIGN_W0;
          tx_k    = tx_phase_q ? ALIGN_K1 : ALIGN_K0;
        end
        ST_READY: begin
          tx_word = user_txdata;
          tx_k    = user_txcharisk;
        end
        default: begin
          tx_word = 16'h0000;
          tx_k    = 2'b00;
        end
      endcase
    end else begin
      tx_word = 16'h0000;
      tx_k    = 2'b00;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      tmo_q            <= 21'd0;
      idle_q           <= 8'd0;
      na_q             <= 4'd0;
      tx_phase_q       <= 1'b0;
      retry_q          <= 8'd0;
      txcominit_q      <= 1'b0;
      txcomwake_q      <= 1'b0;
      txelecidle_q     <= 1'b1;
      link_up_q        <= 1'b0;
      oob_error_q      <= 1'b0;
      txdata_q         <= 16'h0000;
      txcharisk_q      <= 2'b00;
      user_rxdata_q    <= 16'h0000;
      user_rxcharisk_q <= 2'b00;
      user_rxvalid_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      tmo_q            <= tmo_d;
      idle_q           <= idle_d;
      na_q             <= na_d;
      tx_phase_q       <= tx_phase_d;
      retry_q          <= retry_d;
      txcominit_q      <= (state_d == ST_COMINIT) && (state_q != ST_COMINIT);
      txcomwake_q      <= (state_d == ST_COMWAKE) && (state_q != ST_COMWAKE);
      txelecidle_q     <= !((state_d == ST_SEND_D10) || (state_d == ST_SEND_ALIGN) ||
                            (state_d == ST_READY));
      link_up_q        <= (state_d == ST_READY);
      oob_error_q      <= timeout;
      txdata_q         <= tx_word;
      txcharisk_q      <= tx_k;
      user_rxdata_q    <= link_up_q ? rxdata : 16'h0000;
      user_rxcharisk_q <= link_up_q ? rxcharisk : 2'b00;
      user_rxvalid_q   <= link_up_q;
    end
  end

  assign oob_state      = state_q;
  assign link_up        = link_up_q;
  assign oob_error      = oob_error_q;
  assign retry_cnt      = retry_q;
  assign txcominit      = txcominit_q;
  assign txcomwake      = txcomwake_q;
  assign txelecidle     = txelecidle_q;
  assign txdata         = txdata_q;
  assign txcharisk      = txcharisk_q;
  assign user_rxdata    = user_rxdata_q;
  assign user_rxcharisk = user_rxcharisk_q;
  assign user_rxvalid   = user_rxvalid_q;

endmodule
